// File: rtl/gt_frame_pkg.sv
// gt_frame_pkg: shared constants, header field layout, state encoding and header
// validation helper for the GT receive deframer.
package gt_frame_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5C3;
    localparam int          CNT_W_DEFAULT     = 16;

    localparam int SYNC_HI = 31;
    localparam int SYNC_LO = 16;
    localparam int LEN_HI  = 15;
    localparam int LEN_LO  = 0;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } frame_state_t;

    // A header is accepted only with the right sync pattern and a length in 1..max_len.
    function automatic logic header_ok(input logic [31:0] word,
                                       input logic [15:0] sync,
                                       input int          max_len);
        logic [15:0] len;
        len = word[LEN_HI:LEN_LO];
        return (word[SYNC_HI:SYNC_LO] == sync) && (len != 16'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/gt_rx_sat_counter.sv
// gt_rx_sat_counter: status counter with synchronous clear that sticks at all-ones.
module gt_rx_sat_counter
    import gt_frame_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             core_clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one event per cycle, holding at the maximum instead of wrapping.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gt_rx_deframer.sv
// gt_rx_deframer: recovers {header, payload, checksum} frames from the tlast-less
// gt2port stream and re-emits the payload as AXI-stream with tlast/tuser.
// Optional build macro GT_RX_DEFRAMER_TIMEOUT_EN adds a mid-frame idle abort.
module gt_rx_deframer
    import gt_frame_pkg::*;
#(
    parameter int          MAX_LEN        = 256,
    parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
`ifdef GT_RX_DEFRAMER_TIMEOUT_EN
    parameter int          TIMEOUT_CYCLES = 1024,
`endif
    parameter int          CNT_W          = CNT_W_DEFAULT
) (
    input  logic             core_clk,
    input  logic             reset,
    input  logic [31:0]      gt2port_tdata,
    input  logic             gt2port_tvalid,
    output logic             gt2port_tready,
    output logic [31:0]      port_tdata,
    output logic             port_tvalid,
    input  logic             port_tready,
    output logic             port_tlast,
    output logic             port_tuser,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] hdr_err_cnt
);

    frame_state_t state, state_next;

    logic [31:0] acc;
    logic [15:0] remaining;
    logic [31:0] pend_data;
    logic        pend_valid;

    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_user;

    logic in_xfer;
    logic out_free;
    logic hdr_ok;
    logic abort;

    logic load_mid;
    logic load_last;
    logic last_user;
    logic inc_ok;
    logic inc_err;
    logic inc_hdr;

    assign in_xfer  = gt2port_tvalid && gt2port_tready;
    assign out_free = !out_valid || port_tready;
    assign hdr_ok   = header_ok(gt2port_tdata, SYNC_WORD, MAX_LEN);

    assign port_tdata  = out_data;
    assign port_tvalid = out_valid;
    assign port_tlast  = out_last;
    assign port_tuser  = out_user;

`ifdef GT_RX_DEFRAMER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign abort = (state != HUNT) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

    // Count starved cycles inside a frame; parks at the limit until the abort completes.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if ((state == HUNT) || in_xfer) begin
            idle_cnt <= '0;
        end else if (!gt2port_tvalid && !abort) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Hunting always accepts; inside a frame a word is taken only if pend can move out.
    always_comb begin
        gt2port_tready = 1'b0;
        if (reset) begin
            gt2port_tready = 1'b0;
        end else if (state == HUNT) begin
            gt2port_tready = 1'b1;
        end else if (abort) begin
            gt2port_tready = 1'b0;
        end else begin
            gt2port_tready = !pend_valid || out_free;
        end
    end

    // Frame state register.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the strobes that steer the datapath and counters.
    always_comb begin
        state_next = state;
        load_mid   = 1'b0;
        load_last  = 1'b0;
        last_user  = 1'b0;
        inc_ok     = 1'b0;
        inc_err    = 1'b0;
        inc_hdr    = 1'b0;
        if ((state != HUNT) && abort) begin
            if (!pend_valid || out_free) begin
                load_last  = pend_valid;
                last_user  = 1'b1;
                inc_err    = 1'b1;
                state_next = HUNT;
            end
        end else begin
            case (state)
                HUNT: begin
                    if (in_xfer) begin
                        if (hdr_ok) begin
                            state_next = PAYLOAD;
                        end else begin
                            inc_hdr = 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_xfer) begin
                        load_mid = pend_valid;
                        if (remaining == 16'd1) begin
                            state_next = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (in_xfer) begin
                        load_last  = 1'b1;
                        last_user  = (gt2port_tdata != acc);
                        inc_ok     = (gt2port_tdata == acc);
                        inc_err    = (gt2port_tdata != acc);
                        state_next = HUNT;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // Checksum accumulator, length countdown, one-word pend stage and AXI output register.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            acc        <= '0;
            remaining  <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_user   <= 1'b0;
        end else begin
            if (out_valid && port_tready) begin
                out_valid <= 1'b0;
            end
            if (load_mid) begin
                out_data  <= pend_data;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                out_user  <= 1'b0;
            end
            if (load_last) begin
                out_data   <= pend_data;
                out_valid  <= 1'b1;
                out_last   <= 1'b1;
                out_user   <= last_user;
                pend_valid <= 1'b0;
            end
            if ((state == HUNT) && in_xfer && hdr_ok) begin
                acc       <= gt2port_tdata;
                remaining <= gt2port_tdata[LEN_HI:LEN_LO];
            end
            if ((state == PAYLOAD) && in_xfer) begin
                acc        <= acc + gt2port_tdata;
                pend_data  <= gt2port_tdata;
                pend_valid <= 1'b1;
                remaining  <= remaining - 16'd1;
            end
        end
    end

    gt_rx_sat_counter #(.CNT_W(CNT_W)) u_ok_cnt (
        .core_clk (core_clk),
        .reset    (reset),
        .inc      (inc_ok),
        .count    (frame_ok_cnt)
    );

    gt_rx_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .core_clk (core_clk),
        .reset    (reset),
        .inc      (inc_err),
        .count    (frame_err_cnt)
    );

    gt_rx_sat_counter #(.CNT_W(CNT_W)) u_hdr_cnt (
        .core_clk (core_clk),
        .reset    (reset),
        .inc      (inc_hdr),
        .count    (hdr_err_cnt)
    );

endmodule

// File: tb/tb_gt_rx_deframer.sv
// tb_gt_rx_deframer: scoreboard bench for gt_rx_deframer (default build, no timeout).
module tb_gt_rx_deframer;

    localparam int CNT_W = 16;

    logic             core_clk;
    logic             reset;
    logic [31:0]      gt2port_tdata;
    logic             gt2port_tvalid;
    logic             gt2port_tready;
    logic [31:0]      port_tdata;
    logic             port_tvalid;
    logic             port_tready;
    logic             port_tlast;
    logic             port_tuser;
    logic [CNT_W-1:0] frame_ok_cnt;
    logic [CNT_W-1:0] frame_err_cnt;
    logic [CNT_W-1:0] hdr_err_cnt;

    int check_cnt;
    int error_cnt;
    int ready_mode;
    int exp_ok;
    int exp_err;
    int exp_hdr;

    logic [33:0] sb[$];
    logic [31:0] frame_buf[16];

    gt_rx_deframer dut (
        .core_clk       (core_clk),
        .reset          (reset),
        .gt2port_tdata  (gt2port_tdata),
        .gt2port_tvalid (gt2port_tvalid),
        .gt2port_tready (gt2port_tready),
        .port_tdata     (port_tdata),
        .port_tvalid    (port_tvalid),
        .port_tready    (port_tready),
        .port_tlast     (port_tlast),
        .port_tuser     (port_tuser),
        .frame_ok_cnt   (frame_ok_cnt),
        .frame_err_cnt  (frame_err_cnt),
        .hdr_err_cnt    (hdr_err_cnt)
    );

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            error_cnt++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one input word starting at a falling edge; returns at the falling edge after the transfer.
    task automatic applyStimulus(input logic [31:0] word);
        int waited;
        waited = 0;
        gt2port_tdata  = word;
        gt2port_tvalid = 1'b1;
        #1;
        while (!gt2port_tready && waited < 200) begin
            @(negedge core_clk);
            #1;
            waited++;
        end
        if (!gt2port_tready) begin
            checkOutput("input_accept_timeout", 64'(waited), 64'd0);
        end
        @(negedge core_clk);
        gt2port_tvalid = 1'b0;
    endtask

    // Build a frame from frame_buf, push its expected beats, then drive it.
    task automatic sendFrame(input int len, input bit corrupt);
        logic [31:0] hdr;
        logic [31:0] sum;
        hdr = {16'hA5C3, 16'(len)};
        sum = hdr;
        for (int i = 0; i < len; i++) begin
            sum = sum + frame_buf[i];
            sb.push_back({1'(i == len - 1), 1'((i == len - 1) && corrupt), frame_buf[i]});
        end
        if (corrupt) exp_err++;
        else         exp_ok++;
        applyStimulus(hdr);
        for (int i = 0; i < len; i++) begin
            applyStimulus(frame_buf[i]);
        end
        applyStimulus(corrupt ? sum + 32'd1 : sum);
    endtask

    task automatic drainOutput();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge core_clk);
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge core_clk);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_ok_cnt"},  64'(frame_ok_cnt),  64'(exp_ok));
        checkOutput({tag, "_err_cnt"}, 64'(frame_err_cnt), 64'(exp_err));
        checkOutput({tag, "_hdr_cnt"}, 64'(hdr_err_cnt),   64'(exp_hdr));
    endtask

    task automatic pulseReset();
        reset          = 1'b1;
        gt2port_tvalid = 1'b0;
        @(negedge core_clk);
        #1;
        checkOutput("tready_in_reset", 64'(gt2port_tready), 64'd0);
        @(negedge core_clk);
        reset   = 1'b0;
        exp_ok  = 0;
        exp_err = 0;
        exp_hdr = 0;
        @(negedge core_clk);
        #1;
        checkOutput("valid_after_reset", 64'(port_tvalid), 64'd0);
        checkOutput("tready_hunt", 64'(gt2port_tready), 64'd1);
        checkCounters("reset");
        @(negedge core_clk);
    endtask

    // Downstream ready pattern: always ready, alternating, or random.
    initial begin
        port_tready = 1'b1;
        forever begin
            @(negedge core_clk);
            case (ready_mode)
                0:       port_tready = 1'b1;
                1:       port_tready = !port_tready;
                default: port_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: compare each accepted beat against the scoreboard and check stall stability.
    initial begin
        logic [34:0] held;
        logic [33:0] exp_beat;
        bit          held_flag;
        held_flag = 1'b0;
        held      = '0;
        forever begin
            @(negedge core_clk);
            #2;
            if (held_flag) begin
                checkOutput("stall_stable", 64'({port_tvalid, port_tlast, port_tuser, port_tdata}), 64'(held));
            end
            held_flag = port_tvalid && !port_tready && !reset;
            held      = {port_tvalid, port_tlast, port_tuser, port_tdata};
            if (port_tvalid && port_tready && !reset) begin
                if (sb.size() == 0) begin
                    checkOutput("beat_unexpected", 64'd0, 64'd1);
                end else begin
                    exp_beat = sb.pop_front();
                    checkOutput("beat", 64'({port_tlast, port_tuser, port_tdata}), 64'(exp_beat));
                end
            end
        end
    end

    initial begin
        int len;
        bit corrupt;
        check_cnt      = 0;
        error_cnt      = 0;
        ready_mode     = 0;
        exp_ok         = 0;
        exp_err        = 0;
        exp_hdr        = 0;
        reset          = 1'b1;
        gt2port_tvalid = 1'b0;
        gt2port_tdata  = '0;
        @(negedge core_clk);
        pulseReset();

        $display("[TB] good frame 1,2,3");
        frame_buf[0] = 32'd1; frame_buf[1] = 32'd2; frame_buf[2] = 32'd3;
        sendFrame(3, 1'b0);
        drainOutput();
        checkCounters("good");

        $display("[TB] bad checksum frame 1,2,3");
        sendFrame(3, 1'b1);
        drainOutput();
        checkCounters("badsum");

        $display("[TB] junk words then a frame carrying a header-like payload word");
        applyStimulus(32'h0000_1234);
        applyStimulus(32'hA5C3_0000);
        applyStimulus(32'hA5C3_0101);
        exp_hdr += 3;
        frame_buf[0] = 32'hA5C3_0002; frame_buf[1] = 32'h0000_0007;
        sendFrame(2, 1'b0);
        drainOutput();
        checkCounters("hunt");

        $display("[TB] single-word frame under alternating backpressure");
        ready_mode = 1;
        frame_buf[0] = 32'hDEAD_BEEF;
        sendFrame(1, 1'b0);
        drainOutput();
        checkCounters("len1");
        ready_mode = 0;

        $display("[TB] reset in the middle of a frame");
        sb.push_back({1'b0, 1'b0, 32'd10});
        applyStimulus(32'hA5C3_0003);
        applyStimulus(32'd10);
        applyStimulus(32'd20);
        drainOutput();
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge core_clk);
            #1;
            checkOutput("no_valid_after_mid_reset", 64'(port_tvalid), 64'd0);
        end
        @(negedge core_clk);
        frame_buf[0] = 32'h1111_0000; frame_buf[1] = 32'h2222_0000; frame_buf[2] = 32'h3333_0000;
        sendFrame(3, 1'b0);
        drainOutput();
        checkCounters("after_reset");

        $display("[TB] random frames with random backpressure");
        ready_mode = 2;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus({16'h1234, 16'($urandom_range(0, 65535))});
                exp_hdr++;
            end
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                frame_buf[i] = $urandom;
            end
            corrupt = 1'($urandom_range(0, 1));
            sendFrame(len, corrupt);
        end
        drainOutput();
        checkCounters("random");
        ready_mode = 0;

        $display("[TB] header error counter saturation");
        gt2port_tdata  = 32'h0000_1234;
        gt2port_tvalid = 1'b1;
        repeat (65540) @(negedge core_clk);
        gt2port_tvalid = 1'b0;
        exp_hdr = 65535;
        repeat (2) @(negedge core_clk);
        checkCounters("saturate");
        checkOutput("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
